// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line, baud tick and received-byte result signals
//               shared by the UART receiver and its driver/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       os_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    // Driver of the line and tick; consumer of the received words.
    modport master (
        output os_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  rx_busy
    );

    // The receiver itself.
    modport slave (
        input  os_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver, 8N1 by default; defining
//               UART_RX_PARITY_EN builds the 8E1 variant with even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  wire logic  clk,
    input  wire logic  reset,
    uart_rx_if.slave   rx_if
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] c_SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] c_SC_LAST = SCW'(OVERSAMPLE - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;

    logic           r_rx_meta;
    logic           r_rx_s;
    logic [2:0]     r_state;
    logic [2:0]     w_next_state;
    logic [SCW-1:0] r_sc;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic [7:0]     r_rx_data;
    logic           r_rx_valid;
    logic           r_frame_err;
    logic           w_mid;
    logic           w_last;
    logic           w_par_bad;
    logic           w_valid_nxt;
    logic           w_ferr_nxt;
    logic           w_perr_nxt;
    logic           w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_if.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_mid  = rx_if.os_tick && (r_sc == c_SC_MID);
    assign w_last = rx_if.os_tick && (r_sc == c_SC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:
                if (rx_if.os_tick && !r_rx_s) w_next_state = c_ST_START;
            c_ST_START:
                if (w_mid) w_next_state = r_rx_s ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:
`ifdef UART_RX_PARITY_EN
                if (w_last && (r_bit_idx == 3'd7)) w_next_state = c_ST_PARITY;
            c_ST_PARITY:
                if (w_last) w_next_state = c_ST_STOP;
`else
                if (w_last && (r_bit_idx == 3'd7)) w_next_state = c_ST_STOP;
`endif
            c_ST_STOP:
                if (w_last) w_next_state = r_rx_s ? c_ST_IDLE : c_ST_WAIT_HIGH;
            c_ST_WAIT_HIGH:
                if (rx_if.os_tick && r_rx_s) w_next_state = c_ST_IDLE;
            default:
                w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
`ifdef UART_RX_PARITY_EN
                      (r_state == c_ST_PARITY) ||
`endif
                      (r_state == c_ST_STOP);
        w_valid_nxt = (r_state == c_ST_STOP) && w_last && r_rx_s && !w_par_bad;
        w_perr_nxt  = (r_state == c_ST_STOP) && w_last && r_rx_s && w_par_bad;
        w_ferr_nxt  = (r_state == c_ST_STOP) && w_last && !r_rx_s;
    end

    // sc restarts on every state change so each phase counts from its own entry tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc      <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else if (rx_if.os_tick) begin
            if ((r_state == c_ST_IDLE) || (w_next_state != r_state) || (r_sc == c_SC_LAST)) begin
                r_sc <= '0;
            end else begin
                r_sc <= r_sc + 1'b1;
            end
            if (r_state == c_ST_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == c_ST_DATA) && w_last) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad <= 1'b0;
        end else if (r_state == c_ST_START) begin
            r_par_bad <= 1'b0;
        end else if ((r_state == c_ST_PARITY) && w_last) begin
            r_par_bad <= r_rx_s ^ (^r_shift);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr_nxt;
        end
    end

    assign w_par_bad        = r_par_bad;
    assign rx_if.parity_err = r_parity_err;
`else
    assign w_par_bad        = 1'b0;
    assign rx_if.parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
            if (w_valid_nxt) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_if.rx_data   = r_rx_data;
    assign rx_if.rx_valid  = r_rx_valid;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.rx_busy   = w_busy;

endmodule
`default_nettype wire
